operand_forward_ctrl: RTL and testbench

OPERAND_FORWARD_CTRL -- requirements
Module: operand_forward_ctrl

---
 rtl/fwd_pkg.sv | 44 ++++
 rtl/fwd_slot_reg.sv | 27 ++
 rtl/operand_forward_ctrl.sv | 144 ++++++++++++++
 tb/tb_operand_forward_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding controller: select codes,
// the per-stage tracking record and the forwarding priority helpers.
package fwd_pkg;

    // Operand-mux select codes driven into EX
    localparam logic [1:0] SEL_RF    = 2'b00;  // register-file read
    localparam logic [1:0] SEL_EXMEM = 2'b10;  // EX/MEM result
    localparam logic [1:0] SEL_MEMWB = 2'b11;  // MEM/WB writeback data
    localparam logic [1:0] SEL_PWB   = 2'b01;  // post-WB holding register

    // Storage width of a tracked destination; REG_ADDR_W must not exceed it
    localparam int FWD_RD_W  = 8;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_EX   = 0;
    localparam int SLOT_MEM  = 1;
    localparam int SLOT_WB   = 2;
    localparam int SLOT_PWB  = 3;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                write;
        logic                load;
        logic                div;
    } slot_t;

    // A slot feeds a source when it writes that (non-x0) register and the source is read
    function automatic logic slot_match(input slot_t s, input logic [FWD_RD_W-1:0] src,
                                        input logic used);
        return used && s.valid && s.write && (s.rd == src) && (s.rd != '0);
    endfunction

    // Youngest producer wins; the code names where that producer sits once
    // the consumer has advanced into EX
    function automatic logic [1:0] pick_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                            input logic [FWD_RD_W-1:0] src, input logic used);
        if (slot_match(ex, src, used))  return SEL_EXMEM;
        if (slot_match(mem, src, used)) return SEL_MEMWB;
        if (slot_match(wb, src, used))  return SEL_PWB;
        return SEL_RF;
    endfunction

endpackage

// File: rtl/fwd_slot_reg.sv
// One pipeline tracking slot. hold keeps the contents, bubble inserts an
// invalid entry, load captures the upstream record; hold has priority.
import fwd_pkg::*;

module fwd_slot_reg (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  hold,
    input  logic  bubble,
    input  logic  load,
    input  slot_t d,
    output slot_t q
);

    // Slot register: reset/bubble clear the whole record, not just valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble)
                q <= '0;
            else if (load)
                q <= d;
        end
    end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Operand forwarding / hazard controller for a 5-stage in-order pipeline.
// Tracks the EX, MEM, WB and post-WB destinations, registers the EX operand
// selects and raises STALL on load-use hazards.
// Optional macro OPERAND_FORWARD_DIV_STALL_EN: a multi-cycle divide occupies
// EX for DIV_CYCLES cycles, holding ID/EX and freezing the front end.
import fwd_pkg::*;

module operand_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_write,
    input  logic                  id_is_load,
    input  logic                  id_is_div,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  ex_hold
);

    logic [FWD_RD_W-1:0]  rs1_x, rs2_x;
    slot_t                id_info;
    slot_t                slot_d [NUM_SLOTS];
    slot_t                slot_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_hold;
    logic [NUM_SLOTS-1:0] slot_bubble;
    logic                 div_busy;
    logic                 load_use;
    logic [1:0]           sel_a_nxt, sel_b_nxt;

    assign rs1_x = FWD_RD_W'(id_rs1);
    assign rs2_x = FWD_RD_W'(id_rs2);

    // Record of the instruction currently in ID, as it would enter EX
    always_comb begin
        id_info       = '0;
        id_info.valid = 1'b1;
        id_info.rd    = FWD_RD_W'(id_rd);
        id_info.write = id_rd_write;
        id_info.load  = id_is_load;
`ifdef OPERAND_FORWARD_DIV_STALL_EN
        id_info.div   = id_is_div;
`else
        id_info.div   = 1'b0;
`endif
    end

    // Slot chain: each slot takes the next-younger one; EX takes ID
    always_comb begin
        slot_d[SLOT_EX] = id_info;
        for (int i = 1; i < NUM_SLOTS; i++)
            slot_d[i] = slot_q[i-1];
    end

    // EX freezes during a divide; MEM takes a bubble behind it. EX takes a
    // bubble when ID is stalled or killed.
    always_comb begin
        slot_hold              = '0;
        slot_bubble            = '0;
        slot_hold[SLOT_EX]     = ex_hold;
        slot_bubble[SLOT_EX]   = stall | flush;
        slot_bubble[SLOT_MEM]  = ex_hold;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            fwd_slot_reg u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .hold    (slot_hold[g]),
                .bubble  (slot_bubble[g]),
                .load    (1'b1),
                .d       (slot_d[g]),
                .q       (slot_q[g])
            );
        end
    endgenerate

`ifdef OPERAND_FORWARD_DIV_STALL_EN
    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [CNT_W-1:0] div_cnt;

    assign div_busy = (div_cnt != '0);

    // Remaining extra EX cycles of the divide; flush does not cut it short
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (div_busy)
            div_cnt <= div_cnt - 1'b1;
        else if (id_is_div && !stall && !flush)
            div_cnt <= CNT_W'(DIV_CYCLES - 1);
    end
`else
    logic unused_div_cfg;

    assign div_busy       = 1'b0;
    assign unused_div_cfg = ^{id_is_div, 32'(DIV_CYCLES)};
`endif

    // Load in EX feeding ID needs one bubble; a divide hold already covers it
    always_comb begin
        load_use = slot_q[SLOT_EX].load && !div_busy &&
                   (slot_match(slot_q[SLOT_EX], rs1_x, id_rs1_used) ||
                    slot_match(slot_q[SLOT_EX], rs2_x, id_rs2_used));
    end

    // A redirect kills the consumer, so its load-use stall is moot
    assign stall   = div_busy | (load_use & ~flush);
    assign ex_hold = div_busy;

    // Select for the instruction about to enter EX
    always_comb begin
        sel_a_nxt = pick_sel(slot_q[SLOT_EX], slot_q[SLOT_MEM], slot_q[SLOT_WB], rs1_x, id_rs1_used);
        sel_b_nxt = pick_sel(slot_q[SLOT_EX], slot_q[SLOT_MEM], slot_q[SLOT_WB], rs2_x, id_rs2_used);
    end

    // Selects advance with ID and hold while it is frozen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_sel_a <= SEL_RF;
            fwd_sel_b <= SEL_RF;
        end else if (!stall) begin
            fwd_sel_a <= sel_a_nxt;
            fwd_sel_b <= sel_b_nxt;
        end
    end

    // The post-WB slot and most flags beyond EX are tracked but not consulted
    logic unused_slot_bits;
    assign unused_slot_bits = ^{slot_q[SLOT_EX].div, slot_q[SLOT_MEM].load, slot_q[SLOT_MEM].div,
                                slot_q[SLOT_WB].load, slot_q[SLOT_WB].div, slot_q[SLOT_PWB]};

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Self-checking bench for operand_forward_ctrl: directed hazard scenarios with
// literal expectations, then random instruction streams against a model.
module tb_operand_forward_ctrl;

    localparam int AW = 5;
    localparam int DC = 4;
`ifdef OPERAND_FORWARD_DIV_STALL_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_rd_write, id_is_load, id_is_div, flush;
    logic [1:0]    fwd_sel_a, fwd_sel_b;
    logic          stall, ex_hold;

    int checks = 0;
    int errors = 0;

    operand_forward_ctrl #(.REG_ADDR_W(AW), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_write(id_rd_write), .id_is_load(id_is_load), .id_is_div(id_is_div),
        .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .ex_hold(ex_hold)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       v;
        bit [7:0] rd;
        bit       wr;
        bit       ld;
        bit       dv;
    } ins_t;

    ins_t       m_ex, m_mem, m_wb, m_pwb;
    int         m_div_left;
    logic [1:0] m_sel_a, m_sel_b;

    function automatic bit writes_reg(input ins_t i, input logic [AW-1:0] src, input logic used);
        return i.v && i.wr && used && (src != 0) && (i.rd == 8'(src));
    endfunction

    function automatic bit m_busy();
        return DIV_EN && (m_div_left > 0);
    endfunction

    function automatic bit m_stall();
        bit lu;
        lu = m_ex.ld && (writes_reg(m_ex, id_rs1, id_rs1_used) || writes_reg(m_ex, id_rs2, id_rs2_used));
        return m_busy() || (lu && !flush);
    endfunction

    // Where the youngest producer will be when the consumer reaches EX
    function automatic logic [1:0] m_sel(input logic [AW-1:0] src, input logic used);
        ins_t       age[3];
        logic [1:0] code[3];
        age  = '{m_ex, m_mem, m_wb};
        code = '{2'b10, 2'b11, 2'b01};
        for (int k = 0; k < 3; k++)
            if (writes_reg(age[k], src, used)) return code[k];
        return 2'b00;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit stl, bsy;
        if (!reset_n) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0; m_pwb <= '0;
            m_div_left <= 0; m_sel_a <= 2'b00; m_sel_b <= 2'b00;
        end else begin
            stl = m_stall();
            bsy = m_busy();
            if (!stl) begin
                m_sel_a <= m_sel(id_rs1, id_rs1_used);
                m_sel_b <= m_sel(id_rs2, id_rs2_used);
            end
            m_pwb <= m_wb;
            m_wb  <= m_mem;
            if (bsy) begin
                m_mem      <= '0;
                m_div_left <= m_div_left - 1;
            end else begin
                m_mem <= m_ex;
                if (stl || flush) begin
                    m_ex <= '0;
                end else begin
                    m_ex <= '{1'b1, 8'(id_rd), id_rd_write, id_is_load, id_is_div};
                    if (DIV_EN && id_is_div) m_div_left <= DC - 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_sel_a", fwd_sel_a, m_sel_a);
        cmp("model_sel_b", fwd_sel_b, m_sel_b);
        cmp("model_stall", {1'b0, stall}, {1'b0, m_stall()});
        cmp("model_ex_hold", {1'b0, ex_hold}, {1'b0, m_busy()});
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit dv);
        id_rs1 = AW'(rs1); id_rs1_used = u1;
        id_rs2 = AW'(rs2); id_rs2_used = u2;
        id_rd  = AW'(rd);  id_rd_write = wr;
        id_is_load = ld;   id_is_div = dv;
        flush = 1'b0;
    endtask

    task automatic nop();
        put(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        nop();
        #1;
        cmp("reset_sel_a", fwd_sel_a, 2'b00);
        cmp("reset_stall", {1'b0, stall}, 2'b00);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // add x5 then sub reading x5 -> EX/MEM forward
        put(1, 1, 2, 1, 5, 1, 0, 0); step();
        put(5, 1, 0, 0, 10, 1, 0, 0); step();
        cmp("fwd_ex_sel_a", fwd_sel_a, 2'b10);

        // producer, one gap -> MEM/WB data
        put(0, 0, 0, 0, 5, 1, 0, 0); step();
        nop(); step();
        put(5, 1, 0, 0, 12, 1, 0, 0); step();
        cmp("fwd_mem_sel_a", fwd_sel_a, 2'b11);

        // producer, two gaps -> post-WB holding register
        put(0, 0, 0, 0, 5, 1, 0, 0); step();
        nop(); step();
        nop(); step();
        put(0, 0, 5, 1, 13, 1, 0, 0); step();
        cmp("fwd_pwb_sel_b", fwd_sel_b, 2'b01);

        // lw x7 then add using x7 on rs2 -> one stall, then MEM/WB data
        put(1, 1, 0, 0, 7, 1, 1, 0); step();
        put(3, 1, 7, 1, 11, 1, 0, 0); #1;
        cmp("loaduse_stall", {1'b0, stall}, 2'b01);
        cmp("loaduse_no_hold", {1'b0, ex_hold}, 2'b00);
        step();
        cmp("loaduse_stall_once", {1'b0, stall}, 2'b00);
        step();
        cmp("loaduse_sel_b", fwd_sel_b, 2'b11);

        // write to x0 then reader of x0 -> no forward, no stall
        put(1, 1, 0, 0, 0, 1, 1, 0); step();
        put(0, 1, 0, 1, 14, 1, 0, 0); #1;
        cmp("x0_no_stall", {1'b0, stall}, 2'b00);
        step();
        cmp("x0_sel_a", fwd_sel_a, 2'b00);
        cmp("x0_sel_b", fwd_sel_b, 2'b00);

        // back-to-back loads feeding one consumer -> exactly one stall
        put(0, 0, 0, 0, 7, 1, 1, 0); step();
        put(0, 0, 0, 0, 8, 1, 1, 0); #1;
        cmp("ldld_no_stall", {1'b0, stall}, 2'b00);
        step();
        put(7, 1, 8, 1, 15, 1, 0, 0); #1;
        cmp("ldld_stall", {1'b0, stall}, 2'b01);
        step();
        cmp("ldld_stall_once", {1'b0, stall}, 2'b00);
        step();
        cmp("ldld_sel_a", fwd_sel_a, 2'b01);
        cmp("ldld_sel_b", fwd_sel_b, 2'b11);

        // flush coincident with load-use -> no stall, EX bubble
        put(0, 0, 0, 0, 9, 1, 1, 0); step();
        put(9, 1, 0, 0, 16, 1, 0, 0); flush = 1'b1; #1;
        cmp("flush_no_stall", {1'b0, stall}, 2'b00);
        step();
        put(9, 1, 0, 0, 16, 1, 0, 0); #1;
        cmp("flush_bubble_no_stall", {1'b0, stall}, 2'b00);
        step();
        cmp("flush_sel_a", fwd_sel_a, 2'b11);

        // divide occupancy, then a dependent instruction
        put(0, 0, 0, 0, 6, 1, 0, 1); step();
        put(6, 1, 0, 0, 17, 1, 0, 0); #1;
`ifdef OPERAND_FORWARD_DIV_STALL_EN
        for (int c = 0; c < DC - 1; c++) begin
            if (c == 1) flush = 1'b1;
            #1;
            cmp("div_stall", {1'b0, stall}, 2'b01);
            cmp("div_hold", {1'b0, ex_hold}, 2'b01);
            step();
            flush = 1'b0;
        end
        #1;
`endif
        cmp("div_done_stall", {1'b0, stall}, 2'b00);
        cmp("div_done_hold", {1'b0, ex_hold}, 2'b00);
        step();
        cmp("div_dep_sel_a", fwd_sel_a, 2'b10);

        // reset in the middle of a divide
        put(0, 0, 0, 0, 5, 1, 0, 0); step();
        put(5, 1, 0, 0, 6, 1, 0, 1); step();
        nop(); #1;
        cmp("prereset_sel_a", fwd_sel_a, 2'b10);
        reset_n = 1'b0; #1;
        cmp("async_reset_sel_a", fwd_sel_a, 2'b00);
        cmp("async_reset_stall", {1'b0, stall}, 2'b00);
        cmp("async_reset_hold", {1'b0, ex_hold}, 2'b00);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        put(6, 1, 0, 0, 18, 1, 0, 0); #1;
        cmp("postreset_stall", {1'b0, stall}, 2'b00);
        step();
        cmp("postreset_sel_a", fwd_sel_a, 2'b00);

        // random instruction streams; ID is usually frozen while stalled
        for (int n = 0; n < 600; n++) begin
            if (!(m_stall() && $urandom_range(0, 3) != 0)) begin
                put($urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
            end
            flush = ($urandom_range(0, 9) == 0);
            step();
        end

        nop();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
